mux_serializer: RTL

Parallel-to-serial front end for the 8:1 mux stage. Accepts an 8-bit word over a valid/ready handshake, holds it as the mux data input, and steps the 3-bit select through all eight positions. It registers the mux output into a serial bit stream with a valid/ready handshake and frame markers. Back-to-back words stream with no idle bit between them.

---
 rtl/mux_serializer_pkg.sv | 21 ++
 rtl/mux_serializer_ser_bit_cnt.sv | 43 ++++
 rtl/mux_serializer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mux_serializer_pkg.sv
// Shared definitions for the 8:1 mux serializer: FSM states, mux geometry
// and the select endpoints for each bit order.
package mux_pkg;

    localparam int MUX_N     = 8;
    localparam int MUX_SEL_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    function automatic logic [MUX_SEL_W-1:0] SEL_FIRST(input logic msb_first);
        return msb_first ? MUX_SEL_W'(MUX_N - 1) : '0;
    endfunction

    function automatic logic [MUX_SEL_W-1:0] SEL_LAST(input logic msb_first);
        return msb_first ? '0 : MUX_SEL_W'(MUX_N - 1);
    endfunction

endpackage

// File: rtl/mux_serializer_ser_bit_cnt.sv
// Select counter for the serializer: one register drives the mux select,
// and the bit position within the word is derived from it.
module ser_bit_cnt
    import mux_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic [MUX_SEL_W-1:0] load_val_i,
    input  logic                 en_i,
    input  logic                 up_i,
    output logic [MUX_SEL_W-1:0] sel_o,
    output logic [MUX_SEL_W-1:0] cnt_o,
    output logic                 last_o
);

    logic [MUX_SEL_W-1:0] sel_q;
    logic [MUX_SEL_W-1:0] sel_d;

    // Load wins over stepping so a gapless accept restarts the word cleanly.
    always_comb begin
        sel_d = sel_q;
        if (load_i) begin
            sel_d = load_val_i;
        end else if (en_i) begin
            sel_d = up_i ? sel_q + MUX_SEL_W'(1) : sel_q - MUX_SEL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q <= '0;
        end else begin
            sel_q <= sel_d;
        end
    end

    // Counting down from the top is the same as counting up on the inverted select.
    assign sel_o  = sel_q;
    assign cnt_o  = up_i ? sel_q : ~sel_q;
    assign last_o = (cnt_o == MUX_SEL_W'(MUX_N - 1));

endmodule

// File: rtl/mux_serializer.sv
// Parallel-to-serial front end for an external 8:1 mux: holds the word on
// mux_i, walks mux_s, and registers mux_y into a framed serial stream.
module mux_serializer
    import mux_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [MUX_N-1:0]     in_data,
    output logic [MUX_N-1:0]     mux_i,
    output logic [MUX_SEL_W-1:0] mux_s,
    input  logic                 mux_y,
    output logic                 ser_out,
    output logic                 ser_valid,
    input  logic                 ser_ready,
    output logic                 frame_first,
    output logic                 frame_last,
    output logic                 busy
);

    state_e               state_q, state_d;
    logic [MUX_N-1:0]     hold_q, hold_d;
    logic                 ser_out_q, ser_out_d;
    logic                 ser_valid_q, ser_valid_d;
    logic                 first_q, first_d;
    logic                 last_q, last_d;

    logic                 adv;
    logic                 accept;
    logic                 cnt_last;
    logic                 cnt_up;
    logic                 cnt_en;
    logic [MUX_SEL_W-1:0] cnt;
    logic [MUX_SEL_W-1:0] sel;

    // Every register advances only when the output slot is free or being taken.
    assign adv      = !ser_valid_q || ser_ready;
    assign in_ready = !rst && adv && ((state_q == IDLE) || cnt_last);
    assign accept   = in_valid && in_ready;
    assign cnt_up   = !MSB_FIRST;
    assign cnt_en   = adv && (state_q == SHIFT);

    ser_bit_cnt u_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept),
        .load_val_i (SEL_FIRST(MSB_FIRST)),
        .en_i       (cnt_en),
        .up_i       (cnt_up),
        .sel_o      (sel),
        .cnt_o      (cnt),
        .last_o     (cnt_last)
    );

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        ser_out_d   = ser_out_q;
        ser_valid_d = ser_valid_q;
        first_d     = first_q;
        last_d      = last_q;

        if (accept) begin
            hold_d = in_data;
        end

        if (adv) begin
            case (state_q)
                IDLE: begin
                    ser_valid_d = 1'b0;
                    first_d     = 1'b0;
                    last_d      = 1'b0;
                    if (accept) begin
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    ser_out_d   = mux_y;
                    ser_valid_d = 1'b1;
                    first_d     = (cnt == '0);
                    last_d      = cnt_last;
                    // A word accepted on the final bit keeps streaming without a gap.
                    if (cnt_last && !accept) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            first_q     <= first_d;
            last_q      <= last_d;
        end
    end

    assign mux_i       = hold_q;
    assign mux_s       = sel;
    assign ser_out     = ser_out_q;
    assign ser_valid   = ser_valid_q;
    assign frame_first = first_q;
    assign frame_last  = last_q;
    assign busy        = (state_q == SHIFT);

endmodule
